// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_detector_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HUNT = 2'd1,
      ERR  = 2'd2
   } state_t;

   localparam int unsigned DEF_MAX_LEN = 16;
   localparam int unsigned DEF_CNT_W   = 8;

   // Low `len` bits set; callers slice the result down to the pattern width.
   function automatic logic [31:0] len_mask(input int unsigned len);
      if (len >= 32)
         return '1;
      return (32'd1 << len) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_detector_param_shreg.sv
// History shift register with a saturating fill counter.
// Exposes the post-shift history and fill so the caller can evaluate a match
// on the bit being accepted this cycle.
module seq_history_shreg
   import seq_detector_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               din,
   input  logic               fill_clr,
   output logic [MAX_LEN-1:0] hist_nxt,
   output logic [LEN_W-1:0]   fill_nxt
);

   logic [MAX_LEN-1:0] hist_q;
   logic [LEN_W-1:0]   fill_q;

   // Candidate values if the current bit is accepted.
   always_comb begin
      hist_nxt = {hist_q[MAX_LEN-2:0], din};
      fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
   end

   // Shift on accepted bits; fill may be dropped after a non-overlapping match.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (shift) begin
         hist_q <= hist_nxt;
         fill_q <= fill_clr ? '0 : fill_nxt;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with run-time pattern/length load.
// Optional match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detector_param
   import seq_detector_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   output logic               find,
   output logic               armed,
   output logic               cfg_err,
   output logic [CNT_W-1:0]   match_count
);

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic               ovl_q;
   logic               find_q;
   logic               cfg_ok;
   logic               shift_en;
   logic               match_d;
   logic               fill_clr;
   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [LEN_W-1:0]   fill_nxt;

   seq_history_shreg #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_hist (
      .clk      (clk),
      .rst      (rst),
      .clr      (cfg_load),
      .shift    (shift_en),
      .din      (in),
      .fill_clr (fill_clr),
      .hist_nxt (hist_nxt),
      .fill_nxt (fill_nxt)
   );

   // Next state and state-derived outputs.
   always_comb begin
      state_d  = state_q;
      cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
      if (cfg_load)
         state_d = cfg_ok ? HUNT : ERR;
      armed    = (state_q == HUNT);
      cfg_err  = (state_q == ERR);
      shift_en = (state_q == HUNT) && in_valid && !cfg_load;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Latched configuration.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pat_q <= '0;
         len_q <= '0;
         ovl_q <= 1'b0;
      end else if (cfg_load) begin
         pat_q <= cfg_pattern;
         len_q <= cfg_len;
         ovl_q <= cfg_overlap;
      end
   end

   // Compare the post-shift history against the masked pattern.
   always_comb begin
      mask     = MAX_LEN'(len_mask(32'(len_q)));
      match_d  = shift_en && (fill_nxt >= len_q) &&
                 (((hist_nxt ^ pat_q) & mask) == '0);
      fill_clr = match_d && !ovl_q;
   end

   // One-cycle registered match pulse.
   always_ff @(posedge clk) begin
      if (!rst)
         find_q <= 1'b0;
      else
         find_q <= match_d;
   end

   assign find = find_q;

`ifdef SEQDET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count, advanced alongside the find pulse it accounts for.
   always_ff @(posedge clk) begin
      if (!rst || cfg_load)
         cnt_q <= '0;
      else if (match_d && (cnt_q != '1))
         cnt_q <= cnt_q + 1'b1;
   end

   assign match_count = cnt_q;
`else
   assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param against a queue-based model.
module tb_seq_detector_param;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int CNT_W   = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               in;
   logic               in_valid;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               find;
   logic               armed;
   logic               cfg_err;
   logic [CNT_W-1:0]   match_count;

   seq_detector_param #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in          (in),
      .in_valid    (in_valid),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .find        (find),
      .armed       (armed),
      .cfg_err     (cfg_err),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: received bits since the last load, count of bits
   // usable toward the next match, and expected outputs.
   int          q[$];
   int          fresh;
   bit          m_armed, m_err, m_ovl, m_find;
   logic [15:0] m_pat;
   int          m_len;
   int          m_cnt;
   int          find_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic ld, input logic [15:0] pat,
                       input logic [4:0] len, input logic ov, input logic vld, input logic b);
      bit hit;
      rst = r; cfg_load = ld; cfg_pattern = pat; cfg_len = len;
      cfg_overlap = ov; in_valid = vld; in = b;
      @(posedge clk);
      #1;
      if (!r) begin
         m_armed = 0; m_err = 0; m_len = 0; m_pat = '0; m_ovl = 0;
         q.delete(); fresh = 0; m_cnt = 0; m_find = 0;
      end else if (ld) begin
         m_armed = (len >= 1) && (len <= MAX_LEN);
         m_err   = !m_armed;
         m_pat = pat; m_len = int'(len); m_ovl = ov;
         q.delete(); fresh = 0; m_cnt = 0; m_find = 0;
      end else if (m_armed && vld) begin
         q.push_back(int'(b));
         if (q.size() > 40) void'(q.pop_front());
         fresh++;
         hit = (fresh >= m_len);
         if (hit)
            for (int k = 0; k < m_len; k++)
               if (q[q.size() - m_len + k] != int'(m_pat[m_len - 1 - k])) hit = 0;
         m_find = hit;
         if (hit) begin
            if (m_cnt < 3) m_cnt++;
            if (!m_ovl) fresh = 0;
         end
      end else begin
         m_find = 0;
      end
      check("find", 32'(find), 32'(m_find));
      check("armed", 32'(armed), 32'(m_armed));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
`ifdef SEQDET_MATCH_CNT_EN
      check("match_count", 32'(match_count), 32'(m_cnt));
`else
      check("match_count", 32'(match_count), 32'd0);
`endif
      if (find === 1'b1) find_seen++;
   endtask

   task automatic feed(input logic b);
      step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, b);
   endtask

   task automatic stall();
      step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [15:0] pat, input logic [4:0] len, input logic ov);
      step(1'b1, 1'b1, pat, len, ov, 1'b0, 1'b0);
   endtask

   task automatic feed_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) feed(bits[i]);
   endtask

   initial begin
      logic [15:0] rp;
      logic [4:0]  rl;
      int          r;

      step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'hFFFF, 5'd3, 1'b1, 1'b1, 1'b1);

      // Flag pattern, single match after the final 0.
      load(16'b0111110, 5'd7, 1'b0);
      find_seen = 0;
      feed_bits(16'b10111110, 8);
      check("flag_finds", 32'(find_seen), 32'd1);

      // Overlap vs non-overlap on 10101.
      load(16'b101, 5'd3, 1'b1);
      find_seen = 0;
      feed_bits(16'b10101, 5);
      stall();
      check("ovl_finds", 32'(find_seen), 32'd2);
      load(16'b101, 5'd3, 1'b0);
      find_seen = 0;
      feed_bits(16'b10101, 5);
      stall();
      check("novl_finds", 32'(find_seen), 32'd1);

      // Stall in the middle of a pattern.
      load(16'b1100, 5'd4, 1'b0);
      find_seen = 0;
      feed(1'b1); feed(1'b1);
      for (int i = 0; i < 5; i++) stall();
      check("stall_finds", 32'(find_seen), 32'd0);
      feed(1'b0); feed(1'b0);
      check("stall_finds_end", 32'(find_seen), 32'd1);

      // Invalid lengths, then recovery.
      find_seen = 0;
      load(16'h0001, 5'd0, 1'b1);
      for (int i = 0; i < 8; i++) feed(1'b1);
      load(16'h0001, 5'd20, 1'b1);
      for (int i = 0; i < 8; i++) feed(1'b1);
      check("err_finds", 32'(find_seen), 32'd0);
      load(16'h0001, 5'd1, 1'b1);
      check("err_cleared", 32'(cfg_err), 32'd0);

      // Reset mid-pattern discards earlier bits.
      load(16'b0111110, 5'd7, 1'b0);
      find_seen = 0;
      feed_bits(16'b0111, 4);
      step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b1, 1'b1);
      load(16'b0111110, 5'd7, 1'b0);
      feed_bits(16'b110, 3);
      check("rst_mid_finds", 32'(find_seen), 32'd0);

      // Length 1, back-to-back pulses and counter saturation.
      load(16'h0001, 5'd1, 1'b0);
      find_seen = 0;
      for (int i = 0; i < 5; i++) feed(1'b1);
      check("len1_finds", 32'(find_seen), 32'd5);

      // Load together with a valid bit: bit discarded.
      load(16'h0001, 5'd1, 1'b1);
      find_seen = 0;
      step(1'b1, 1'b1, 16'h0001, 5'd1, 1'b1, 1'b1, 1'b1);
      check("load_wins", 32'(find_seen), 32'd0);

      // Full-width pattern.
      load(16'hB3C5, 5'd16, 1'b0);
      find_seen = 0;
      feed_bits(16'hB3C5, 16);
      check("maxlen_finds", 32'(find_seen), 32'd1);

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 1) begin
            step(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'($urandom), 1'($urandom));
         end else if (r < 4) begin
            rp = 16'($urandom);
            case ($urandom_range(0, 9))
               0:       rl = 5'd0;
               1:       rl = 5'($urandom_range(17, 31));
               2:       rl = 5'($urandom_range(7, 16));
               default: rl = 5'($urandom_range(1, 5));
            endcase
            step(1'b1, 1'b1, rp, rl, 1'($urandom), 1'($urandom), 1'($urandom));
         end else begin
            step(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, ($urandom_range(0, 9) < 8), 1'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector: one bit per accepted clock, pattern and length loaded at run time, one-cycle `find` pulse per match.
- Overlapping and non-overlapping match modes.
- Generalises the fixed single-pattern detector FSM.
- Sits on the serial receive path (flag/sync-word detection) ahead of framing logic.

Parameters:
- MAX_LEN, 16, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- in  input  1  serial data bit.
- in_valid  input  1  `in` is sampled only when high.
- cfg_load  input  1  latch `cfg_pattern`/`cfg_len`/`cfg_overlap` this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] last.
- cfg_len  input  LEN_W  active pattern length.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- find  output  1  registered one-cycle pulse per match.
- armed  output  1  valid configuration held, detector hunting.
- cfg_err  output  1  last load had an invalid length (sticky until the next load).
- match_count  output  CNT_W  saturating match count (see Optional Feature).

Behaviour:
- Reset (rst=0 at posedge): state IDLE; history, fill count, pattern, length cleared. `find`=0, `armed`=0, `cfg_err`=0, `match_count`=0. Reset overrides every other input, including mid-pattern.
- States:
  - IDLE: no valid configuration.
  - HUNT: comparing.
  - ERR: invalid configuration.
- Transitions on `cfg_load`:
  - From any state, cfg_len in 1..MAX_LEN → HUNT; history and fill cleared.
  - cfg_len = 0 or > MAX_LEN → ERR; `cfg_err`=1.
- `armed` = (state == HUNT). ERR and IDLE never assert `find`.
- HUNT, in_valid=1: history <= {history[MAX_LEN-2:0], in}; fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the updated history: fill_next ≥ len and history_next[len-1:0] == pattern[len-1:0].
- On a match, `find`=1 in the cycle after the completing bit is sampled (latency 1 clk); otherwise `find`=0.
- Non-overlap mode: after a match, fill resets to 0, so the next match needs len fresh bits.
- Overlap mode: fill is not cleared after a match; a suffix of one match may start the next.
- in_valid=0: history, fill and match evaluation are held; `find`=0 that cycle.
- cfg_load together with in_valid in the same cycle: load wins, the input bit is discarded, no `find`.
- Length 1: every matching valid bit produces `find`. Back-to-back pulses are legal.

Optional Feature:
- Macro SEQDET_MATCH_CNT_EN.
- Defined: `match_count` increments on every `find`, saturates at 2^CNT_W-1, and clears on reset or `cfg_load`.
- Not defined: no counter logic; `match_count` is tied to 0.

Decomposition:
- Package seq_detector_pkg holds:
  - state enum (IDLE, HUNT, ERR);
  - default MAX_LEN/CNT_W constants;
  - a function giving the length mask from len.
- One natural sub-module, seq_history_shreg: the shift register plus saturating fill counter, with shift-enable and clear.
- Compare logic, FSM and counter stay in the top module.

Test Plan:
- Load pattern 7'b0111110, len 7, overlap 0; stream 1,0,1,1,1,1,1,0 (valid every cycle) → `find`=1 exactly once, in the cycle after the final 0; `armed`=1 throughout.
- Overlap check: pattern 3'b101, len 3, stream 1,0,1,0,1.
  - overlap=1 → `find` pulses after bit 3 and after bit 5.
  - overlap=0 → one pulse, after bit 3 only.
- Stall: pattern 4'b1100; stream 1,1 then in_valid=0 for 5 cycles, then 0,0 → single `find` after the last 0; no `find` during the stall.
- Invalid load: cfg_len=0 → `cfg_err`=1, `armed`=0, and no `find` for any stream. A later valid load clears `cfg_err`.
- Reset mid-pattern: pattern 0111110, feed 0,1,1,1, assert rst=0 for 1 cycle, reload, feed 1,1,0 → no `find`, because the earlier bits were discarded.
- SEQDET_MATCH_CNT_EN with CNT_W=2: pattern 1'b1, len 1, stream 5 ones → `match_count` reads 1,2,3,3,3 (saturates at 3).
